vx_hpdcache_mem_arbiter: RTL and testbench
==========================================

Name: vx_hpdcache_mem_arbiter

Overview:
- Shares the single Vortex memory bus port between the HPDcache read-request channel and its split write-request (address + data) channels.
- Joins each write's address and data beats into one write command.
- Arbitrates round-robin between the read command and the joined write command through a registered request stage.
- Routes read responses back, and generates write acknowledgements locally, because the Vortex bus returns no write response.

Parameters:
- ADDR_WIDTH, 32, memory address width
- DATA_WIDTH, 512, line/beat data width
- ID_WIDTH, 4, HPDcache transaction id width
- MEM_TAG_WIDTH, ID_WIDTH+1, bus tag width; MSB = 1 for writes, 0 for reads
- WACK_DEPTH, 4, write-ack FIFO depth (power of two, >=2)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- rd_req_valid  in  1  read request valid
- rd_req_ready  out  1  read request accepted
- rd_req_addr  in  ADDR_WIDTH  read address
- rd_req_id  in  ID_WIDTH  read id
- wr_req_valid  in  1  write address valid
- wr_req_ready  out  1  write address accepted
- wr_req_addr  in  ADDR_WIDTH  write address
- wr_req_id  in  ID_WIDTH  write id
- wr_data_valid  in  1  write data valid
- wr_data_ready  out  1  write data accepted
- wr_data  in  DATA_WIDTH  write data
- wr_be  in  DATA_WIDTH/8  write byte enables
- rd_rsp_valid  out  1  read response valid
- rd_rsp_ready  in  1  read response accepted
- rd_rsp_id  out  ID_WIDTH  read response id
- rd_rsp_data  out  DATA_WIDTH  read response data
- wr_rsp_valid  out  1  write ack valid
- wr_rsp_ready  in  1  write ack accepted
- wr_rsp_id  out  ID_WIDTH  write ack id
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus request accepted
- mem_req_rw  out  1  1 = write
- mem_req_addr  out  ADDR_WIDTH  bus address
- mem_req_data  out  DATA_WIDTH  bus write data; 0 on reads
- mem_req_byteen  out  DATA_WIDTH/8  byte enables; all-ones on reads
- mem_req_tag  out  MEM_TAG_WIDTH  {rw, id}
- mem_rsp_valid  in  1  bus response valid
- mem_rsp_ready  out  1  bus response accepted
- mem_rsp_data  in  DATA_WIDTH  bus response data
- mem_rsp_tag  in  MEM_TAG_WIDTH  bus response tag

Behaviour:
- Reset (async, reset_n=0):
  - Output register, both write-join slots and the wack FIFO are empty.
  - last_grant = WRITE, so the first contention goes to the read.
  - All valid/ready outputs are 0.
  - A reset mid-transaction discards everything held; nothing is replayed.
- Write join: two independent one-entry slots, addr slot {addr, id} and data slot {data, be}.
  - wr_req_ready = !addr_full; wr_data_ready = !data_full.
  - Each slot fills on its own handshake; address and data may arrive in any order or in the same cycle.
- Write candidate: addr_full && data_full && (wack_count + out_is_write) < WACK_DEPTH.
- Read candidate: rd_req_valid.
- Output register: load = !mem_req_valid || mem_req_ready.
  - When load is high and at least one candidate exists, the winner is latched and mem_req_valid=1 next cycle.
  - Payload stays stable while mem_req_valid && !mem_req_ready; no retraction.
- Arbitration:
  - With a single candidate, that candidate wins.
  - With both candidates, the side opposite last_grant wins; last_grant updates on each load.
  - rd_req_ready = load && read wins (combinational in rd_req_valid).
  - A winning write clears both join slots in the load cycle, so the slots can refill in the next cycle.
- Latency:
  - Read: accept at cycle N, mem_req_valid at N+1.
  - Write: both slots full at N+1 after handshakes at N, mem_req_valid at N+2.
  - Back-to-back loads while mem_req_ready=1 give one command per cycle.
- Tag: mem_req_tag = {rw, id}.
- Write ack: on mem handshake with rw=1, push id into the wack FIFO.
  - wr_rsp_valid = !empty; pop on wr_rsp_valid && wr_rsp_ready.
  - A simultaneous push and pop leaves the count unchanged.
  - The reservation rule above guarantees the FIFO never overflows.
- Read response: combinational pass-through.
  - rd_rsp_valid = mem_rsp_valid; mem_rsp_ready = rd_rsp_ready.
  - rd_rsp_id = mem_rsp_tag[ID_WIDTH-1:0].
  - A mem_rsp_tag MSB of 1 is illegal; a simulation assertion fires.

Test Plan:
- Single read addr=0x1000 id=3, mem_req_ready=1 -> next cycle mem_req_valid=1, rw=0, tag=0x03, byteen all-ones, data=0; response tag=0x03 data=D -> rd_rsp id=3 data=D same cycle.
- Write data one cycle before address (addr=0x2000 id=5, be=0xF) -> one bus write with tag=0x15, addr=0x2000; wr_rsp_valid id=5 one cycle after handshake.
- Read and joined write both pending continuously after reset, mem_req_ready=1 -> grants alternate R,W,R,W.
- mem_req_ready=0 for 5 cycles with a command latched -> mem_req_* stable all 5 cycles, rd_req_ready=0, no new load.
- wr_rsp_ready=0, four writes issued (WACK_DEPTH=4) -> fifth joined write is not issued and its slots stay full; one ack pop -> fifth write issues.
- reset_n asserted while the output register and join slots are full -> mem_req_valid, wr_rsp_valid, wr_req_ready and wr_data_ready all 0 immediately; after release, wr_req_ready=1 and wr_data_ready=1.

Source files
------------

// File: rtl/vx_hpdcache_mem_arbiter.sv
// HPDcache -> Vortex memory bus adapter.
// Joins the split write address/data channels into one command, arbitrates
// round-robin between reads and writes into a registered request stage, passes
// read responses straight through, and acknowledges writes locally.
`timescale 1ns/1ps
module vx_hpdcache_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned MEM_TAG_WIDTH = ID_WIDTH + 1,
  parameter int unsigned WACK_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      rd_req_valid,
  output logic                      rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]     rd_req_addr,
  input  logic [ID_WIDTH-1:0]       rd_req_id,
  input  logic                      wr_req_valid,
  output logic                      wr_req_ready,
  input  logic [ADDR_WIDTH-1:0]     wr_req_addr,
  input  logic [ID_WIDTH-1:0]       wr_req_id,
  input  logic                      wr_data_valid,
  output logic                      wr_data_ready,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_be,
  output logic                      rd_rsp_valid,
  input  logic                      rd_rsp_ready,
  output logic [ID_WIDTH-1:0]       rd_rsp_id,
  output logic [DATA_WIDTH-1:0]     rd_rsp_data,
  output logic                      wr_rsp_valid,
  input  logic                      wr_rsp_ready,
  output logic [ID_WIDTH-1:0]       wr_rsp_id,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_rw,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr,
  output logic [DATA_WIDTH-1:0]     mem_req_data,
  output logic [DATA_WIDTH/8-1:0]   mem_req_byteen,
  output logic [MEM_TAG_WIDTH-1:0]  mem_req_tag,
  input  logic                      mem_rsp_valid,
  output logic                      mem_rsp_ready,
  input  logic [DATA_WIDTH-1:0]     mem_rsp_data,
  input  logic [MEM_TAG_WIDTH-1:0]  mem_rsp_tag
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PTR_W    = $clog2(WACK_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

  grant_e                 last_grant;
  logic                   active;

  logic                   addr_full;
  logic [ADDR_WIDTH-1:0]  slot_addr;
  logic [ID_WIDTH-1:0]    slot_id;
  logic                   data_full;
  logic [DATA_WIDTH-1:0]  slot_data;
  logic [BE_WIDTH-1:0]    slot_be;

  logic [ID_WIDTH-1:0]    wack_mem [WACK_DEPTH];
  logic [PTR_W-1:0]       wack_wr_ptr;
  logic [PTR_W-1:0]       wack_rd_ptr;
  logic [CNT_W-1:0]       wack_count;
  logic [CNT_W-1:0]       wack_reserved;
  logic                   wack_push;
  logic                   wack_pop;

  logic                   load;
  logic                   out_is_write;
  logic                   wr_cand;
  logic                   rd_win;
  logic                   wr_win;

  // Arbitration, reservation and handshake decode.
  always_comb begin
    out_is_write  = mem_req_valid && mem_req_rw;
    // A write sitting in the output register has not been pushed into the
    // ack FIFO yet, so it holds a slot there until it hands off.
    wack_reserved = wack_count + {{(CNT_W-1){1'b0}}, out_is_write};
    wr_cand       = addr_full && data_full && (wack_reserved < CNT_W'(WACK_DEPTH));
    load          = active && (!mem_req_valid || mem_req_ready);
    rd_win        = rd_req_valid && (!wr_cand || (last_grant == GRANT_WRITE));
    wr_win        = wr_cand && (!rd_req_valid || (last_grant == GRANT_READ));
    rd_req_ready  = load && rd_win;
    wr_req_ready  = active && !addr_full;
    wr_data_ready = active && !data_full;
    wack_push     = mem_req_valid && mem_req_ready && mem_req_rw;
    wack_pop      = wr_rsp_valid && wr_rsp_ready;
  end

  // Readies stay low until the first clock after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) active <= 1'b0;
    else          active <= 1'b1;
  end

  // Write join slots: each fills on its own handshake, both drain on a write grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_full <= 1'b0;
      slot_addr <= '0;
      slot_id   <= '0;
      data_full <= 1'b0;
      slot_data <= '0;
      slot_be   <= '0;
    end else begin
      if (wr_req_valid && wr_req_ready) begin
        addr_full <= 1'b1;
        slot_addr <= wr_req_addr;
        slot_id   <= wr_req_id;
      end else if (load && wr_win) begin
        addr_full <= 1'b0;
      end
      if (wr_data_valid && wr_data_ready) begin
        data_full <= 1'b1;
        slot_data <= wr_data;
        slot_be   <= wr_be;
      end else if (load && wr_win) begin
        data_full <= 1'b0;
      end
    end
  end

  // Registered bus request stage with round-robin grant history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_valid  <= 1'b0;
      mem_req_rw     <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_data   <= '0;
      mem_req_byteen <= '0;
      mem_req_tag    <= '0;
      last_grant     <= GRANT_WRITE;
    end else if (load) begin
      mem_req_valid <= rd_win || wr_win;
      if (wr_win) begin
        mem_req_rw     <= 1'b1;
        mem_req_addr   <= slot_addr;
        mem_req_data   <= slot_data;
        mem_req_byteen <= slot_be;
        mem_req_tag    <= {1'b1, slot_id};
        last_grant     <= GRANT_WRITE;
      end else if (rd_win) begin
        mem_req_rw     <= 1'b0;
        mem_req_addr   <= rd_req_addr;
        mem_req_data   <= '0;
        mem_req_byteen <= '1;
        mem_req_tag    <= {1'b0, rd_req_id};
        last_grant     <= GRANT_READ;
      end
    end
  end

  // Write-ack FIFO storage.
  always_ff @(posedge clk) begin
    if (wack_push) wack_mem[wack_wr_ptr] <= mem_req_tag[ID_WIDTH-1:0];
  end

  // Write-ack FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wack_wr_ptr <= '0;
      wack_rd_ptr <= '0;
      wack_count  <= '0;
    end else begin
      if (wack_push) wack_wr_ptr <= wack_wr_ptr + 1'b1;
      if (wack_pop)  wack_rd_ptr <= wack_rd_ptr + 1'b1;
      if (wack_push && !wack_pop)      wack_count <= wack_count + 1'b1;
      else if (!wack_push && wack_pop) wack_count <= wack_count - 1'b1;
    end
  end

  assign wr_rsp_valid  = (wack_count != '0);
  assign wr_rsp_id     = wack_mem[wack_rd_ptr];

  assign rd_rsp_valid  = mem_rsp_valid;
  assign mem_rsp_ready = rd_rsp_ready;
  assign rd_rsp_id     = mem_rsp_tag[ID_WIDTH-1:0];
  assign rd_rsp_data   = mem_rsp_data;

  // The bus never answers writes, so a write-tagged response is a protocol error.
  a_no_write_rsp: assert property (@(posedge clk) disable iff (!reset_n)
    !(mem_rsp_valid && mem_rsp_tag[MEM_TAG_WIDTH-1]));

endmodule

// File: tb/tb_vx_hpdcache_mem_arbiter.sv
// Self-checking bench for vx_hpdcache_mem_arbiter.
`timescale 1ns/1ps
module tb_vx_hpdcache_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int TW = IW + 1;
  localparam int WD = 4;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic [IW-1:0] rd_req_id;
  logic wr_req_valid, wr_req_ready;
  logic [AW-1:0] wr_req_addr;
  logic [IW-1:0] wr_req_id;
  logic wr_data_valid, wr_data_ready;
  logic [DW-1:0] wr_data;
  logic [BW-1:0] wr_be;
  logic rd_rsp_valid, rd_rsp_ready;
  logic [IW-1:0] rd_rsp_id;
  logic [DW-1:0] rd_rsp_data;
  logic wr_rsp_valid, wr_rsp_ready;
  logic [IW-1:0] wr_rsp_id;
  logic mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic [BW-1:0] mem_req_byteen;
  logic [TW-1:0] mem_req_tag;
  logic mem_rsp_valid, mem_rsp_ready;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;

  always #5 clk = ~clk;

  vx_hpdcache_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .MEM_TAG_WIDTH(TW), .WACK_DEPTH(WD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_id(rd_req_id),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_id(wr_req_id),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .wr_data(wr_data), .wr_be(wr_be),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
    .rd_rsp_id(rd_rsp_id), .rd_rsp_data(rd_rsp_data),
    .wr_rsp_valid(wr_rsp_valid), .wr_rsp_ready(wr_rsp_ready), .wr_rsp_id(wr_rsp_id),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_byteen(mem_req_byteen),
    .mem_req_tag(mem_req_tag),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag)
  );

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic [TW-1:0] tag;
  } req_t;

  typedef struct {
    logic          v;
    logic          r;
    logic [TW-1:0] tag;
    logic [DW-1:0] d;
    logic          ev;
    logic          er;
    logic [IW-1:0] eid;
    logic [DW-1:0] ed;
  } rsp_vec_t;

  req_t          exp_q[$];
  logic [IW-1:0] ack_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t mk(input logic rw, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [BW-1:0] be,
                              input logic [TW-1:0] tag);
    req_t r;
    r.rw = rw; r.addr = a; r.data = d; r.be = be; r.tag = tag;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for bus requests.
  always @(negedge clk) begin
    if (reset_n && mem_req_valid && mem_req_ready) begin
      chk("mem_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        req_t e;
        e = exp_q.pop_front();
        chk("mem_rw", 64'(mem_req_rw), 64'(e.rw));
        chk("mem_addr", 64'(mem_req_addr), 64'(e.addr));
        chk("mem_data", mem_req_data, e.data);
        chk("mem_byteen", 64'(mem_req_byteen), 64'(e.be));
        chk("mem_tag", 64'(mem_req_tag), 64'(e.tag));
      end
    end
  end

  // Scoreboard for write acks.
  always @(negedge clk) begin
    if (reset_n && wr_rsp_valid && wr_rsp_ready) begin
      chk("ack_q_nonempty", 64'(ack_q.size() != 0), 64'd1);
      if (ack_q.size() != 0) chk("ack_id", 64'(wr_rsp_id), 64'(ack_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic drain();
    int c = 0;
    while ((exp_q.size() != 0 || ack_q.size() != 0) && c < 100) begin
      step();
      c++;
    end
    chk("drain_empty", 64'(exp_q.size() + ack_q.size()), 64'd0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [IW-1:0] id,
                          input logic [DW-1:0] d, input logic [BW-1:0] be);
    logic a_done = 1'b0;
    logic d_done = 1'b0;
    logic ah, dh;
    wr_req_addr = a; wr_req_id = id; wr_data = d; wr_be = be;
    for (int c = 0; c < 20 && !(a_done && d_done); c++) begin
      wr_req_valid  = !a_done;
      wr_data_valid = !d_done;
      #1;
      ah = wr_req_valid && wr_req_ready;
      dh = wr_data_valid && wr_data_ready;
      step();
      a_done = a_done | ah;
      d_done = d_done | dh;
    end
    wr_req_valid  = 1'b0;
    wr_data_valid = 1'b0;
    chk("write_accept", 64'(a_done && d_done), 64'd1);
  endtask

  rsp_vec_t rv[4];

  initial begin
    rd_req_valid = 0; rd_req_addr = '0; rd_req_id = '0;
    wr_req_valid = 0; wr_req_addr = '0; wr_req_id = '0;
    wr_data_valid = 0; wr_data = '0; wr_be = '0;
    rd_rsp_ready = 0; wr_rsp_ready = 1; mem_req_ready = 1;
    mem_rsp_valid = 0; mem_rsp_data = '0; mem_rsp_tag = '0;

    rv[0] = '{1'b1, 1'b1, 5'h03, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b1, 4'h3, 64'hDEAD_BEEF_0123_4567};
    rv[1] = '{1'b1, 1'b0, 5'h0A, 64'h1111_2222_3333_4444, 1'b1, 1'b0, 4'hA, 64'h1111_2222_3333_4444};
    rv[2] = '{1'b0, 1'b1, 5'h07, 64'h0,                   1'b0, 1'b1, 4'h7, 64'h0};
    rv[3] = '{1'b1, 1'b1, 5'h0F, 64'hFFFF_0000_FFFF_0000, 1'b1, 1'b1, 4'hF, 64'hFFFF_0000_FFFF_0000};

    // Reset state, with requests pending on every input channel.
    rd_req_valid = 1; wr_req_valid = 1; wr_data_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_wr_rsp_valid", 64'(wr_rsp_valid), 64'd0);
    chk("rst_rd_req_ready", 64'(rd_req_ready), 64'd0);
    chk("rst_wr_req_ready", 64'(wr_req_ready), 64'd0);
    chk("rst_wr_data_ready", 64'(wr_data_ready), 64'd0);
    rd_req_valid = 0; wr_req_valid = 0; wr_data_valid = 0;
    reset_n = 1;
    step();
    chk("post_rst_wr_req_ready", 64'(wr_req_ready), 64'd1);
    chk("post_rst_wr_data_ready", 64'(wr_data_ready), 64'd1);

    // Single read.
    rd_req_valid = 1; rd_req_addr = 32'h1000; rd_req_id = 4'd3;
    exp_q.push_back(mk(1'b0, 32'h1000, 64'h0, 8'hFF, 5'h03));
    #1;
    chk("rd_ready_single", 64'(rd_req_ready), 64'd1);
    step();
    rd_req_valid = 0;
    chk("rd_lat_valid", 64'(mem_req_valid), 64'd1);
    chk("rd_lat_rw", 64'(mem_req_rw), 64'd0);
    chk("rd_lat_tag", 64'(mem_req_tag), 64'h03);
    chk("rd_lat_byteen", 64'(mem_req_byteen), 64'hFF);
    chk("rd_lat_data", mem_req_data, 64'h0);
    step();
    chk("rd_after_valid", 64'(mem_req_valid), 64'd0);

    // Read response pass-through vectors.
    rd_rsp_ready = 0;
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid = rv[i].v; rd_rsp_ready = rv[i].r;
      mem_rsp_tag = rv[i].tag; mem_rsp_data = rv[i].d;
      #1;
      chk("rsp_valid", 64'(rd_rsp_valid), 64'(rv[i].ev));
      chk("rsp_ready", 64'(mem_rsp_ready), 64'(rv[i].er));
      chk("rsp_id", 64'(rd_rsp_id), 64'(rv[i].eid));
      chk("rsp_data", rd_rsp_data, rv[i].ed);
    end
    mem_rsp_valid = 0; rd_rsp_ready = 0; mem_rsp_tag = '0;
    step();

    // Write data one cycle ahead of its address.
    wr_data_valid = 1; wr_data = 64'hCAFE_F00D_1234_5678; wr_be = 8'h0F;
    #1;
    chk("wd_ready_empty", 64'(wr_data_ready), 64'd1);
    step();
    wr_data_valid = 0;
    chk("wd_ready_full", 64'(wr_data_ready), 64'd0);
    wr_req_valid = 1; wr_req_addr = 32'h2000; wr_req_id = 4'd5;
    exp_q.push_back(mk(1'b1, 32'h2000, 64'hCAFE_F00D_1234_5678, 8'h0F, 5'h15));
    ack_q.push_back(4'd5);
    #1;
    chk("wa_ready_empty", 64'(wr_req_ready), 64'd1);
    step();
    wr_req_valid = 0;
    chk("wr_join_not_yet", 64'(mem_req_valid), 64'd0);
    chk("wa_ready_full", 64'(wr_req_ready), 64'd0);
    step();
    chk("wr_lat_valid", 64'(mem_req_valid), 64'd1);
    chk("wr_lat_tag", 64'(mem_req_tag), 64'h15);
    chk("wr_lat_addr", 64'(mem_req_addr), 64'h2000);
    chk("wr_slots_cleared_a", 64'(wr_req_ready), 64'd1);
    chk("wr_slots_cleared_d", 64'(wr_data_ready), 64'd1);
    chk("wack_not_early", 64'(wr_rsp_valid), 64'd0);
    step();
    chk("wack_valid", 64'(wr_rsp_valid), 64'd1);
    chk("wack_id", 64'(wr_rsp_id), 64'd5);
    step();
    chk("wack_popped", 64'(wr_rsp_valid), 64'd0);
    drain();

    // Round-robin alternation from reset: R0 W0 R1 W1 R2 W2.
    reset_n = 0;
    #2;
    reset_n = 1;
    step(); step();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(1'b0, 32'h3000 + 32'(k * 64), 64'h0, 8'hFF, {1'b0, 4'(k)}));
      exp_q.push_back(mk(1'b1, 32'h4000 + 32'(k * 64), 64'hA0 + 64'(k), 8'h3C, {1'b1, 4'(8 + k)}));
      ack_q.push_back(4'(8 + k));
    end
    begin
      int ri = 0, wa = 0, wdi = 0;
      logic rh, ah, dh;
      for (int c = 0; c < 40 && (ri < 3 || wa < 3 || wdi < 3); c++) begin
        rd_req_valid = (ri < 3); rd_req_addr = 32'h3000 + 32'(ri * 64); rd_req_id = 4'(ri);
        wr_req_valid = (wa < 3); wr_req_addr = 32'h4000 + 32'(wa * 64); wr_req_id = 4'(8 + wa);
        wr_data_valid = (wdi < 3); wr_data = 64'hA0 + 64'(wdi); wr_be = 8'h3C;
        #1;
        rh = rd_req_valid && rd_req_ready;
        ah = wr_req_valid && wr_req_ready;
        dh = wr_data_valid && wr_data_ready;
        step();
        if (rh) ri++;
        if (ah) wa++;
        if (dh) wdi++;
      end
      rd_req_valid = 0; wr_req_valid = 0; wr_data_valid = 0;
    end
    drain();

    // Back-pressure: payload holds for 5 stalled cycles.
    mem_req_ready = 0;
    rd_req_valid = 1; rd_req_addr = 32'h5000; rd_req_id = 4'd1;
    exp_q.push_back(mk(1'b0, 32'h5000, 64'h0, 8'hFF, 5'h01));
    step();
    rd_req_addr = 32'h5040; rd_req_id = 4'd2;
    exp_q.push_back(mk(1'b0, 32'h5040, 64'h0, 8'hFF, 5'h02));
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", 64'(mem_req_valid), 64'd1);
      chk("stall_addr", 64'(mem_req_addr), 64'h5000);
      chk("stall_tag", 64'(mem_req_tag), 64'h01);
      chk("stall_rd_ready", 64'(rd_req_ready), 64'd0);
      step();
    end
    mem_req_ready = 1;
    #1;
    chk("unstall_rd_ready", 64'(rd_req_ready), 64'd1);
    step();
    rd_req_valid = 0;
    drain();

    // Write-ack FIFO full holds back the fifth write.
    wr_rsp_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(mk(1'b1, 32'h6000 + 32'(i * 64), 64'hB0 + 64'(i), 8'hFF, {1'b1, 4'(i)}));
      ack_q.push_back(4'(i));
      do_write(32'h6000 + 32'(i * 64), 4'(i), 64'hB0 + 64'(i), 8'hFF);
    end
    repeat (4) step();
    chk("wfull_no_issue", 64'(mem_req_valid), 64'd0);
    chk("wfull_addr_held", 64'(wr_req_ready), 64'd0);
    chk("wfull_data_held", 64'(wr_data_ready), 64'd0);
    chk("wfull_ack_valid", 64'(wr_rsp_valid), 64'd1);
    chk("wfull_ack_head", 64'(wr_rsp_id), 64'd1);
    wr_rsp_ready = 1;
    step();
    wr_rsp_ready = 0;
    step();
    chk("wfull_fifth_valid", 64'(mem_req_valid), 64'd1);
    chk("wfull_fifth_tag", 64'(mem_req_tag), 64'h15);
    wr_rsp_ready = 1;
    drain();

    // Reset with a command latched, slots full and an ack pending.
    wr_rsp_ready = 0;
    exp_q.push_back(mk(1'b1, 32'h7100, 64'hC6, 8'hFF, 5'h16));
    ack_q.push_back(4'd6);
    do_write(32'h7100, 4'd6, 64'hC6, 8'hFF);
    repeat (3) step();
    mem_req_ready = 0;
    rd_req_valid = 1; rd_req_addr = 32'h7000; rd_req_id = 4'd7;
    exp_q.push_back(mk(1'b0, 32'h7000, 64'h0, 8'hFF, 5'h07));
    step();
    rd_req_valid = 0;
    do_write(32'h7200, 4'd9, 64'hC9, 8'hFF);
    chk("prerst_valid", 64'(mem_req_valid), 64'd1);
    chk("prerst_slots", 64'(wr_req_ready), 64'd0);
    chk("prerst_ack", 64'(wr_rsp_valid), 64'd1);
    #2;
    reset_n = 0;
    exp_q.delete();
    ack_q.delete();
    #1;
    chk("midrst_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("midrst_wr_rsp_valid", 64'(wr_rsp_valid), 64'd0);
    chk("midrst_wr_req_ready", 64'(wr_req_ready), 64'd0);
    chk("midrst_wr_data_ready", 64'(wr_data_ready), 64'd0);
    step();
    reset_n = 1;
    mem_req_ready = 1; wr_rsp_ready = 1;
    step();
    chk("relrst_wr_req_ready", 64'(wr_req_ready), 64'd1);
    chk("relrst_wr_data_ready", 64'(wr_data_ready), 64'd1);
    repeat (3) step();
    chk("relrst_no_replay", 64'(mem_req_valid), 64'd0);
    rd_req_valid = 1; rd_req_addr = 32'h8000; rd_req_id = 4'd2;
    exp_q.push_back(mk(1'b0, 32'h8000, 64'h0, 8'hFF, 5'h02));
    step();
    rd_req_valid = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
